id_ex_stage: RTL and testbench



---
 rtl/id_ex_if.sv | 41 ++++
 rtl/id_ex_stage.sv | 108 ++++++++++
 tb/tb_id_ex_stage.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/id_ex_if.sv
// ID/EX stage bus: decoded ID fields and forwarding inputs toward the stage, ALU operands back out.
interface id_ex_if #(parameter int WIDTH = 32);
  logic             stall;
  logic             flush;
  logic             idValid;
  logic [4:0]       idRs;
  logic [4:0]       idRt;
  logic [WIDTH-1:0] idRsData;
  logic [WIDTH-1:0] idRtData;
  logic [15:0]      idImm;
  logic [4:0]       idShamt;
  logic [5:0]       idFunct;
  logic [1:0]       idAluOp;
  logic             idAluSrc;
  logic             exMemRegWrite;
  logic [4:0]       exMemRd;
  logic [WIDTH-1:0] exMemResult;
  logic             memWbRegWrite;
  logic [4:0]       memWbRd;
  logic [WIDTH-1:0] memWbResult;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [3:0]       opCode;
  logic [4:0]       shiftAmt;
  logic             exValid;
  logic             illegalOp;

  modport master (
    output stall, flush, idValid, idRs, idRt, idRsData, idRtData, idImm, idShamt,
           idFunct, idAluOp, idAluSrc, exMemRegWrite, exMemRd, exMemResult,
           memWbRegWrite, memWbRd, memWbResult,
    input  in1, in2, opCode, shiftAmt, exValid, illegalOp
  );

  modport slave (
    input  stall, flush, idValid, idRs, idRt, idRsData, idRtData, idImm, idShamt,
           idFunct, idAluOp, idAluSrc, exMemRegWrite, exMemRd, exMemResult,
           memWbRegWrite, memWbRd, memWbResult,
    output in1, in2, opCode, shiftAmt, exValid, illegalOp
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU opCode decode and EX/MEM, MEM/WB operand forwarding.
module id_ex_stage #(
  parameter int WIDTH = 32
) (
  input logic   clk,
  input logic   rst_n,
  id_ex_if.slave bus
);

  typedef struct packed {
    logic             valid;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic [15:0]      imm;
    logic             alu_src;
    logic             is_shift;
    logic             zext;
    logic [3:0]       op;
    logic [4:0]       shamt;
    logic             illegal;
  } stage_t;

  stage_t stage_q, stage_d, id_fields;

  always_comb begin
    id_fields          = '0;
    id_fields.valid    = 1'b1;
    id_fields.rs       = bus.idRs;
    id_fields.rt       = bus.idRt;
    id_fields.rs_data  = bus.idRsData;
    id_fields.rt_data  = bus.idRtData;
    id_fields.imm      = bus.idImm;
    id_fields.alu_src  = bus.idAluSrc;
    case (bus.idAluOp)
      2'b00: id_fields.op = 4'b0010;
      2'b01: id_fields.op = 4'b0110;
      2'b11: id_fields.op = 4'b0001;
      default: begin
        case (bus.idFunct)
          6'b100000: id_fields.op = 4'b0010;
          6'b100010: id_fields.op = 4'b0110;
          6'b100100: id_fields.op = 4'b0000;
          6'b100101: id_fields.op = 4'b0001;
          6'b100111: id_fields.op = 4'b1100;
          6'b101010: id_fields.op = 4'b0111;
          6'b000000: begin
            id_fields.op       = 4'b0100;
            id_fields.is_shift = 1'b1;
          end
          6'b000010: begin
            id_fields.op       = 4'b0101;
            id_fields.is_shift = 1'b1;
          end
          default: begin
            id_fields.op      = 4'b0000;
            id_fields.illegal = 1'b1;
          end
        endcase
      end
    endcase
    // Only ori zero-extends; an R-type or shares opCode 0001 but keeps sign extension.
    id_fields.zext  = (id_fields.op == 4'b0001) && (bus.idAluOp == 2'b11);
    id_fields.shamt = id_fields.is_shift ? bus.idShamt : 5'd0;
  end

  always_comb begin
    stage_d = stage_q;
    if (bus.flush || (!bus.stall && !bus.idValid)) begin
      stage_d = '0;
    end else if (!bus.stall) begin
      stage_d = id_fields;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  function automatic logic [WIDTH-1:0] forward(input logic [4:0] r, input logic [WIDTH-1:0] stored);
    if (bus.exMemRegWrite && (bus.exMemRd != 5'd0) && (bus.exMemRd == r)) begin
      return bus.exMemResult;
    end else if (bus.memWbRegWrite && (bus.memWbRd != 5'd0) && (bus.memWbRd == r)) begin
      return bus.memWbResult;
    end
    return stored;
  endfunction

  logic [WIDTH-1:0] fwd_rs, fwd_rt, imm_ext;

  assign fwd_rs  = forward(stage_q.rs, stage_q.rs_data);
  assign fwd_rt  = forward(stage_q.rt, stage_q.rt_data);
  assign imm_ext = stage_q.zext ? {{(WIDTH-16){1'b0}}, stage_q.imm}
                                : {{(WIDTH-16){stage_q.imm[15]}}, stage_q.imm};

  assign bus.in1       = stage_q.is_shift ? fwd_rt : fwd_rs;
  assign bus.in2       = stage_q.alu_src ? imm_ext : fwd_rt;
  assign bus.opCode    = stage_q.op;
  assign bus.shiftAmt  = stage_q.shamt;
  assign bus.exValid   = stage_q.valid;
  assign bus.illegalOp = stage_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed checks of decode, forwarding, immediates, stall/flush and async reset for id_ex_stage.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  id_ex_if #(.WIDTH(32)) bus_if ();

  id_ex_stage #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [1:0] aluop, input logic [5:0] funct, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [15:0] imm, input logic [4:0] shamt, input logic alusrc);
    bus_if.idValid  = 1'b1;
    bus_if.idAluOp  = aluop;
    bus_if.idFunct  = funct;
    bus_if.idRs     = rs;
    bus_if.idRt     = rt;
    bus_if.idRsData = rsd;
    bus_if.idRtData = rtd;
    bus_if.idImm    = imm;
    bus_if.idShamt  = shamt;
    bus_if.idAluSrc = alusrc;
  endtask

  task automatic clear_fwd();
    bus_if.exMemRegWrite = 1'b0;
    bus_if.exMemRd       = 5'd0;
    bus_if.exMemResult   = 32'd0;
    bus_if.memWbRegWrite = 1'b0;
    bus_if.memWbRd       = 5'd0;
    bus_if.memWbResult   = 32'd0;
    #1;
  endtask

  initial begin
    bus_if.stall = 1'b0;
    bus_if.flush = 1'b0;
    set_id(2'b00, 6'd0, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0, 5'd0, 1'b0);
    bus_if.idValid = 1'b0;
    clear_fwd();
    #12 rst_n = 1'b1;
    #1;
    check("rst_opcode", {28'd0, bus_if.opCode}, 32'h0);
    check("rst_valid", {31'd0, bus_if.exValid}, 32'h0);
    check("rst_in1", bus_if.in1, 32'h0);
    check("rst_in2", bus_if.in2, 32'h0);
    check("rst_illegal", {31'd0, bus_if.illegalOp}, 32'h0);

    // R-type add; shamt must be masked for a non-shift
    set_id(2'b10, 6'b100000, 5'd1, 5'd2, 32'd5, 32'd7, 16'h0, 5'd9, 1'b0);
    step();
    check("add_opcode", {28'd0, bus_if.opCode}, 32'h2);
    check("add_in1", bus_if.in1, 32'd5);
    check("add_in2", bus_if.in2, 32'd7);
    check("add_valid", {31'd0, bus_if.exValid}, 32'h1);
    check("add_shamt", {27'd0, bus_if.shiftAmt}, 32'h0);

    // forwarding priority, evaluated combinationally
    set_id(2'b10, 6'b100000, 5'd8, 5'd2, 32'd55, 32'd7, 16'h0, 5'd0, 1'b0);
    step();
    bus_if.exMemRegWrite = 1'b1; bus_if.exMemRd = 5'd8; bus_if.exMemResult = 32'd100;
    bus_if.memWbRegWrite = 1'b1; bus_if.memWbRd = 5'd8; bus_if.memWbResult = 32'd200;
    #1 check("fwd_exmem", bus_if.in1, 32'd100);
    bus_if.exMemRegWrite = 1'b0;
    #1 check("fwd_memwb", bus_if.in1, 32'd200);
    bus_if.memWbRd = 5'd0;
    #1 check("fwd_rd0", bus_if.in1, 32'd55);
    bus_if.memWbRd = 5'd2;
    #1 check("fwd_rt_in2", bus_if.in2, 32'd200);
    check("fwd_rt_in1", bus_if.in1, 32'd55);
    clear_fwd();
    set_id(2'b10, 6'b100000, 5'd0, 5'd2, 32'h33, 32'd7, 16'h0, 5'd0, 1'b0);
    step();
    bus_if.exMemRegWrite = 1'b1; bus_if.exMemRd = 5'd0; bus_if.exMemResult = 32'd999;
    #1 check("fwd_reg0", bus_if.in1, 32'h33);
    clear_fwd();

    // shifts take rt as in1
    set_id(2'b10, 6'b000000, 5'd1, 5'd2, 32'd5, 32'd1, 16'h0, 5'd3, 1'b0);
    step();
    check("sll_opcode", {28'd0, bus_if.opCode}, 32'h4);
    check("sll_in1", bus_if.in1, 32'd1);
    check("sll_shamt", {27'd0, bus_if.shiftAmt}, 32'd3);
    set_id(2'b10, 6'b000010, 5'd1, 5'd2, 32'd5, 32'h80, 16'h0, 5'd7, 1'b0);
    step();
    check("srl_opcode", {28'd0, bus_if.opCode}, 32'h5);
    check("srl_in1", bus_if.in1, 32'h80);
    check("srl_shamt", {27'd0, bus_if.shiftAmt}, 32'd7);

    // immediate extension
    set_id(2'b00, 6'b000000, 5'd1, 5'd2, 32'd5, 32'd7, 16'hFFFF, 5'd0, 1'b1);
    step();
    check("lw_opcode", {28'd0, bus_if.opCode}, 32'h2);
    check("lw_in2", bus_if.in2, 32'hFFFFFFFF);
    set_id(2'b11, 6'b000000, 5'd1, 5'd2, 32'd5, 32'd7, 16'hFFFF, 5'd0, 1'b1);
    step();
    check("ori_opcode", {28'd0, bus_if.opCode}, 32'h1);
    check("ori_in2", bus_if.in2, 32'h0000FFFF);
    set_id(2'b01, 6'b000000, 5'd1, 5'd2, 32'd5, 32'd7, 16'h8000, 5'd0, 1'b1);
    step();
    check("beq_opcode", {28'd0, bus_if.opCode}, 32'h6);
    check("beq_in2", bus_if.in2, 32'hFFFF8000);
    set_id(2'b10, 6'b100101, 5'd1, 5'd2, 32'd5, 32'd7, 16'hFFFF, 5'd0, 1'b1);
    step();
    check("or_opcode", {28'd0, bus_if.opCode}, 32'h1);
    check("or_in2_sext", bus_if.in2, 32'hFFFFFFFF);

    // stall holds, forwarding still tracks
    set_id(2'b10, 6'b100111, 5'd4, 5'd2, 32'h11, 32'd7, 16'h0, 5'd0, 1'b0);
    step();
    check("nor_opcode", {28'd0, bus_if.opCode}, 32'hC);
    bus_if.stall = 1'b1;
    set_id(2'b10, 6'b101010, 5'd4, 5'd2, 32'h22, 32'd7, 16'h0, 5'd0, 1'b0);
    step();
    step();
    check("stall_opcode", {28'd0, bus_if.opCode}, 32'hC);
    check("stall_in1", bus_if.in1, 32'h11);
    bus_if.exMemRegWrite = 1'b1; bus_if.exMemRd = 5'd4; bus_if.exMemResult = 32'hABC;
    #1 check("stall_fwd", bus_if.in1, 32'hABC);
    clear_fwd();
    bus_if.idValid = 1'b0;
    step();
    check("stall_novalid", {31'd0, bus_if.exValid}, 32'h1);
    bus_if.idValid = 1'b1;
    bus_if.stall = 1'b0;
    step();
    check("slt_opcode", {28'd0, bus_if.opCode}, 32'h7);
    check("slt_in1", bus_if.in1, 32'h22);

    // flush beats stall
    bus_if.stall = 1'b1;
    bus_if.flush = 1'b1;
    step();
    check("flush_valid", {31'd0, bus_if.exValid}, 32'h0);
    check("flush_opcode", {28'd0, bus_if.opCode}, 32'h0);
    check("flush_in1", bus_if.in1, 32'h0);
    bus_if.stall = 1'b0;
    bus_if.flush = 1'b0;

    // idValid=0 without stall loads a bubble
    set_id(2'b01, 6'b000000, 5'd1, 5'd2, 32'd5, 32'd7, 16'h0, 5'd0, 1'b0);
    step();
    check("pre_bubble_valid", {31'd0, bus_if.exValid}, 32'h1);
    bus_if.idValid = 1'b0;
    step();
    check("bubble_valid", {31'd0, bus_if.exValid}, 32'h0);
    check("bubble_in1", bus_if.in1, 32'h0);

    // illegal funct
    set_id(2'b10, 6'b001000, 5'd1, 5'd2, 32'd5, 32'd7, 16'h0, 5'd0, 1'b0);
    step();
    check("ill_flag", {31'd0, bus_if.illegalOp}, 32'h1);
    check("ill_opcode", {28'd0, bus_if.opCode}, 32'h0);
    check("ill_valid", {31'd0, bus_if.exValid}, 32'h1);
    set_id(2'b10, 6'b100100, 5'd1, 5'd2, 32'd5, 32'd7, 16'h0, 5'd0, 1'b0);
    step();
    check("and_flag", {31'd0, bus_if.illegalOp}, 32'h0);
    check("and_opcode", {28'd0, bus_if.opCode}, 32'h0);

    // async reset mid-instruction
    set_id(2'b01, 6'b000000, 5'd1, 5'd2, 32'd5, 32'd7, 16'h0, 5'd0, 1'b0);
    step();
    check("pre_rst_opcode", {28'd0, bus_if.opCode}, 32'h6);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, bus_if.exValid}, 32'h0);
    check("arst_opcode", {28'd0, bus_if.opCode}, 32'h0);
    check("arst_in1", bus_if.in1, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
